// File: rtl/nibble_serializer_pkg.sv
// Shared constants, payload types and FSM encoding for the nibble serializer.
package nibble_serializer_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned NIB_N  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned GAP_W  = 4;

  // Receiver layout selector, sampled with the word.
  localparam logic FMT_NIBBLE = 1'b0;
  localparam logic FMT_LANE   = 1'b1;

  // Four nibbles of one frame; entry [k] is the k-th nibble on the wire.
  typedef logic [NIB_N-1:0][NIB_W-1:0] nib_arr_t;

  // S_ prefix keeps the GAP state distinct from the GAP parameter.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serializer_if.sv
// Word-side valid/ready handshake of the nibble serializer.
//   in_valid : word offered        in_ready : word can be taken (combinational)
//   in_data  : 16-bit word         in_fmt   : layout, 0 nibble / 1 bit-lane
interface nibble_serializer_if;
  import nibble_serializer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_fmt;

  modport master (output in_valid, output in_data, output in_fmt, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_fmt, output in_ready);
endinterface

// File: rtl/nibble_serializer_order.sv
// Combinational word-to-nibble ordering for both receiver layouts.
//   in_data : word to split     fmt : 0 nibble layout, 1 bit-lane layout
//   nib_c   : nib_c[k] is the k-th nibble sent
module nibble_order
  import nibble_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] in_data,
  input  logic              fmt,
  output nib_arr_t          nib_c
);

  // Nibble layout: most significant nibble first.
  // Bit-lane layout: bit i of nibble k carries word bit 4i+3-k, so lane i
  // of the receiver rebuilds word nibble i after four shifts.
  for (genvar k = 0; k < int'(NIB_N); k++) begin : g_nib
    for (genvar i = 0; i < int'(NIB_W); i++) begin : g_bit
      assign nib_c[k][i] = (fmt == FMT_LANE) ? in_data[4*i + 3 - k]
                                             : in_data[12 - 4*k + i];
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Serializes a 16-bit word into four 4-bit nibbles, oldest first.
//   clk, rst_n : clock, async active-low reset
//   ena        : global enable, low freezes state and blanks the stream
//   in_if      : word handshake (in_ready combinational)
//   data_o, valid_o, sof_o, last_o : registered nibble stream
//   busy       : registered, state not IDLE
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  nibble_serializer_if.slave in_if,
  output logic [NIB_W-1:0]  data_o,
  output logic              valid_o,
  output logic              sof_o,
  output logic              last_o,
  output logic              busy
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB_N - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
  localparam logic             GAP_NONE = (GAP == 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  nib_arr_t           nib_q, nib_d;
  logic [NIB_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               sof_q, sof_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;

  nib_arr_t           ord_nib_c;
  logic               in_ready_c;
  logic               accept_c;

  nibble_order u_order (
    .in_data (in_if.in_data),
    .fmt     (in_if.in_fmt),
    .nib_c   (ord_nib_c)
  );

  // Ready in IDLE, or on the last-nibble edge when frames may abut.
  assign in_ready_c = ena && ((state_q == S_IDLE) ||
                              ((state_q == S_SEND) && (idx_q == IDX_LAST) && GAP_NONE));
  assign accept_c       = in_ready_c && in_if.in_valid;
  assign in_if.in_ready = in_ready_c;

  // Next state and stream outputs; stream defaults to blank.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    nib_d   = nib_q;
    data_d  = '0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    last_d  = 1'b0;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            nib_d   = ord_nib_c;
            data_d  = ord_nib_c[0];
            valid_d = 1'b1;
            sof_d   = 1'b1;
            idx_d   = IDX_W'(1);
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          data_d  = nib_q[idx_q];
          valid_d = 1'b1;
          // idx 0 in SEND only occurs for a back-to-back frame start.
          sof_d   = (idx_q == '0);
          last_d  = (idx_q == IDX_LAST);
          idx_d   = IDX_W'(idx_q + IDX_W'(1));
          if (idx_q == IDX_LAST) begin
            if (accept_c) begin
              nib_d = ord_nib_c;
            end else if (!GAP_NONE) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_GAP: begin
          gap_d = GAP_W'(gap_q - GAP_W'(1));
          if (gap_q <= GAP_W'(1)) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      nib_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      nib_q   <= nib_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sof_o   = sof_q;
  assign last_o  = last_q;
  assign busy    = busy_q;

endmodule
